morse_round_judge: RTL and testbench

//  Downstream of the player1/player2 Morse entry stages. Latches player 1's 10-bit Morse code as the round

---
 rtl/morse_round_judge.sv | 180 ++++++++++++++++++
 tb/tb_morse_round_judge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_round_judge.sv
// ============================================================================
// morse_round_judge : latches a Morse secret, judges the guess, tracks score/lives
// Revision 1.0
// ============================================================================
`default_nettype none

module morse_round_judge #(
  parameter int CODE_W        = 10,
  parameter int SCORE_W       = 8,
  parameter int MAX_LIVES     = 3,
  parameter int GUESS_TIMEOUT = 1000,
  parameter int RESULT_CYCLES = 50
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               start_i,
  input  logic [CODE_W-1:0]  p1_code_i,
  input  logic               p1_done_i,
  input  logic [CODE_W-1:0]  p2_code_i,
  input  logic               p2_done_i,
  output logic               clr_p1_o,
  output logic               clr_p2_o,
  output logic [2:0]         state_o,
  output logic               match_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [2:0]         lives_o,
  output logic               game_over_o
);

  localparam int C_TMAX    = (GUESS_TIMEOUT > RESULT_CYCLES) ? GUESS_TIMEOUT : RESULT_CYCLES;
  localparam int C_TIMER_W = $clog2(C_TMAX + 1);

  localparam logic [C_TIMER_W-1:0] C_GUESS_LAST  = C_TIMER_W'(GUESS_TIMEOUT - 1);
  localparam logic [C_TIMER_W-1:0] C_RESULT_LAST = C_TIMER_W'(RESULT_CYCLES - 1);
  localparam logic [C_TIMER_W-1:0] C_TIMER_ONE   = C_TIMER_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_P1   = 3'd1,
    S_WAIT_P2   = 3'd2,
    S_COMPARE   = 3'd3,
    S_RESULT    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    secret_q, secret_d;
  logic [CODE_W-1:0]    guess_q, guess_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic                 match_q, match_d;
  logic [C_TIMER_W-1:0] timer_q, timer_d;
  logic                 clr_p1_q, clr_p1_d;
  logic                 clr_p2_q, clr_p2_d;
  logic                 game_over_q, game_over_d;

  logic [2:0]           lives_dec;
  logic                 p1_valid;
  logic                 p2_valid;

  assign lives_dec = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
  assign p1_valid  = p1_done_i && (p1_code_i != '0);
  assign p2_valid  = p2_done_i && (p2_code_i != '0);

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    score_d   = score_q;
    lives_d   = lives_q;
    match_d   = match_q;
    timer_d   = timer_q;
    clr_p1_d  = 1'b0;
    clr_p2_d  = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_i) begin
          state_d  = S_WAIT_P1;
          lives_d  = 3'(MAX_LIVES);
          score_d  = '0;
          match_d  = 1'b0;
          clr_p1_d = 1'b1;
          clr_p2_d = 1'b1;
        end
      end
      S_WAIT_P1: begin
        if (p1_valid) begin
          state_d  = S_WAIT_P2;
          secret_d = p1_code_i;
          timer_d  = '0;
          clr_p2_d = 1'b1;
        end
      end
      S_WAIT_P2: begin
        // A valid guess arriving on the final timeout cycle still counts.
        if (p2_valid) begin
          state_d = S_COMPARE;
          guess_d = p2_code_i;
        end else if (timer_q == C_GUESS_LAST) begin
          state_d = S_RESULT;
          match_d = 1'b0;
          lives_d = lives_dec;
          timer_d = '0;
        end else begin
          timer_d = timer_q + C_TIMER_ONE;
        end
      end
      S_COMPARE: begin
        state_d = S_RESULT;
        timer_d = '0;
        if (guess_q == secret_q) begin
          match_d = 1'b1;
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
          end
        end else begin
          match_d = 1'b0;
          lives_d = lives_dec;
        end
      end
      S_RESULT: begin
        if (timer_q == C_RESULT_LAST) begin
          timer_d = '0;
          if (lives_q == 3'd0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d  = S_WAIT_P1;
            clr_p1_d = 1'b1;
            clr_p2_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + C_TIMER_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clock_i) begin
    if (resetn_i) begin
      state_q     <= S_IDLE;
      secret_q    <= '0;
      guess_q     <= '0;
      score_q     <= '0;
      lives_q     <= 3'd0;
      match_q     <= 1'b0;
      timer_q     <= '0;
      clr_p1_q    <= 1'b0;
      clr_p2_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      secret_q    <= secret_d;
      guess_q     <= guess_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      match_q     <= match_d;
      timer_q     <= timer_d;
      clr_p1_q    <= clr_p1_d;
      clr_p2_q    <= clr_p2_d;
      game_over_q <= game_over_d;
    end
  end

  assign clr_p1_o    = clr_p1_q;
  assign clr_p2_o    = clr_p2_q;
  assign state_o     = state_q;
  assign match_o     = match_q;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign game_over_o = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_round_judge.sv
// ============================================================================
// tb_morse_round_judge : directed bench with a result scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_morse_round_judge;

  localparam int CW = 10;
  localparam int SW = 2;
  localparam int ML = 3;
  localparam int GT = 20;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] p1_code;
  logic          p1_done;
  logic [CW-1:0] p2_code;
  logic          p2_done;
  logic          clr_p1;
  logic          clr_p2;
  logic [2:0]    state;
  logic          match;
  logic [SW-1:0] score;
  logic [2:0]    lives;
  logic          game_over;

  always #5 clk = ~clk;

  morse_round_judge #(
    .CODE_W(CW), .SCORE_W(SW), .MAX_LIVES(ML),
    .GUESS_TIMEOUT(GT), .RESULT_CYCLES(RC)
  ) dut (
    .clock_i(clk), .resetn_i(resetn), .start_i(start),
    .p1_code_i(p1_code), .p1_done_i(p1_done),
    .p2_code_i(p2_code), .p2_done_i(p2_done),
    .clr_p1_o(clr_p1), .clr_p2_o(clr_p2), .state_o(state),
    .match_o(match), .score_o(score), .lives_o(lives), .game_over_o(game_over)
  );

  typedef struct packed {
    logic          m;
    logic [SW-1:0] s;
    logic [2:0]    l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_score = 0;
  int   m_lives = 0;

  localparam logic [CW-1:0] SECRET = 10'b0101110000;
  localparam logic [CW-1:0] WRONG  = 10'b0000000001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit m);
    exp_t e;
    if (m) m_score = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
    else   m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    e.m = m;
    e.s = SW'(m_score);
    e.l = 3'(m_lives);
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_clr"}, {30'd0, clr_p1, clr_p2}, 32'd0);
    chk({tag, "_gover"}, 32'(game_over), 32'd0);
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    m_lives = ML;
    m_score = 0;
    chk({tag, "_state"}, 32'(state), 32'd1);
    chk({tag, "_lives"}, 32'(lives), 32'(ML));
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_clr"}, {30'd0, clr_p1, clr_p2}, 32'd3);
    chk({tag, "_gover"}, 32'(game_over), 32'd0);
    step();
    chk({tag, "_clr_drop"}, {30'd0, clr_p1, clr_p2}, 32'd0);
  endtask

  task automatic enter_p2(input string tag, input logic [CW-1:0] code);
    p1_code = code;
    p1_done = 1'b1;
    step();
    p1_done = 1'b0;
    chk({tag, "_wp2"}, 32'(state), 32'd2);
    chk({tag, "_clr_p2only"}, {30'd0, clr_p1, clr_p2}, 32'd1);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 0;
    while (state !== 3'd4 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_reach_result"}, 32'(state), 32'd4);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_match"}, 32'(match), 32'(e.m));
      chk({tag, "_score"}, 32'(score), 32'(e.s));
      chk({tag, "_lives"}, 32'(lives), 32'(e.l));
    end
  endtask

  task automatic finish_result(input string tag, input bit to_over);
    for (int i = 1; i < RC; i++) begin
      step();
      chk({tag, "_hold"}, 32'(state), 32'd4);
    end
    step();
    if (to_over) begin
      chk({tag, "_over_state"}, 32'(state), 32'd5);
      chk({tag, "_over_flag"}, 32'(game_over), 32'd1);
      chk({tag, "_over_noclr"}, {30'd0, clr_p1, clr_p2}, 32'd0);
    end else begin
      chk({tag, "_next_state"}, 32'(state), 32'd1);
      chk({tag, "_next_clr"}, {30'd0, clr_p1, clr_p2}, 32'd3);
      chk({tag, "_next_gover"}, 32'(game_over), 32'd0);
    end
  endtask

  task automatic do_round(input string tag, input logic [CW-1:0] sec, input logic [CW-1:0] gss);
    enter_p2(tag, sec);
    p2_code = gss;
    p2_done = 1'b1;
    push_exp(gss == sec);
    step();
    p2_done = 1'b0;
    chk({tag, "_compare"}, 32'(state), 32'd3);
    wait_result(tag);
    finish_result(tag, m_lives == 0);
  endtask

  initial begin
    resetn  = 1'b1;
    start   = 1'b0;
    p1_code = '0;
    p1_done = 1'b0;
    p2_code = '0;
    p2_done = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    resetn = 1'b0;
    step();
    chk("idle_hold", 32'(state), 32'd0);

    start_game("start");

    // Empty secret plus an out-of-phase guess must both be ignored.
    p1_code = '0;
    p1_done = 1'b1;
    p2_code = SECRET;
    p2_done = 1'b1;
    step();
    p1_done = 1'b0;
    p2_done = 1'b0;
    chk("empty_p1_stay", 32'(state), 32'd1);

    // Correct round; a late p1_done in WAIT_P2 must not overwrite the secret.
    enter_p2("rnd1", SECRET);
    p1_code = 10'h3FF;
    p1_done = 1'b1;
    step();
    chk("p1_in_wp2_stay", 32'(state), 32'd2);
    p2_code = SECRET;
    p2_done = 1'b1;
    push_exp(1'b1);
    step();
    p1_done = 1'b0;
    p2_done = 1'b0;
    chk("rnd1_compare", 32'(state), 32'd3);
    wait_result("rnd1");
    finish_result("rnd1", 1'b0);

    do_round("sat2", 10'h155, 10'h155);
    do_round("sat3", 10'h2AA, 10'h2AA);
    do_round("sat4", 10'h0F3, 10'h0F3);

    // Timeout with no guess: a miss after exactly GT cycles in WAIT_P2.
    enter_p2("tmo", SECRET);
    push_exp(1'b0);
    for (int i = 1; i < GT; i++) begin
      step();
      chk("tmo_wait", 32'(state), 32'd2);
    end
    step();
    chk("tmo_result_now", 32'(state), 32'd4);
    wait_result("tmo");
    finish_result("tmo", m_lives == 0);

    // Valid guess on the timeout cycle wins over the miss.
    enter_p2("tmo_edge", SECRET);
    for (int i = 1; i < GT; i++) step();
    p2_code = SECRET;
    p2_done = 1'b1;
    push_exp(1'b1);
    step();
    p2_done = 1'b0;
    chk("tmo_edge_compare", 32'(state), 32'd3);
    wait_result("tmo_edge");
    finish_result("tmo_edge", m_lives == 0);

    do_round("miss_a", SECRET, WRONG);
    do_round("miss_b", SECRET, WRONG);
    step();
    chk("over_stay", 32'(state), 32'd5);

    start_game("restart");
    do_round("w1", SECRET, WRONG);
    do_round("w2", SECRET, WRONG);
    do_round("w3", SECRET, WRONG);

    start_game("again");
    enter_p2("mid", SECRET);
    step();
    step();
    resetn = 1'b1;
    step();
    chk_reset_outputs("midreset");
    resetn = 1'b0;
    step();
    chk("after_midreset_idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
